// File: rtl/layer_norm_pkg.sv
// Shared defaults and coefficient type for the binarising layer-norm stage.
package layer_norm_pkg;

    localparam int LN_CH      = 16;
    localparam int LN_T_STEPS = 30;
    localparam int LN_COEF_W  = 8;
    localparam int LN_NUM_BLK = 8;

    // One affine coefficient pair for a (block, time step) entry.
    typedef struct packed {
        logic signed [LN_COEF_W-1:0] alpha;
        logic signed [LN_COEF_W-1:0] beta;
    } coef_t;

    // Spike decision for one channel: (d ? alpha : 0) + beta > 0, evaluated
    // one bit wider than the coefficients so the sum can never wrap.
    function automatic logic spike_bit(input logic d, input coef_t c);
        logic signed [LN_COEF_W:0] term_s;
        logic signed [LN_COEF_W:0] sum_s;
        term_s = d ? (LN_COEF_W+1)'(c.alpha) : {(LN_COEF_W+1){1'b0}};
        sum_s  = term_s + (LN_COEF_W+1)'(c.beta);
        return (!sum_s[LN_COEF_W]) && (sum_s != {(LN_COEF_W+1){1'b0}});
    endfunction

endpackage

// File: rtl/ln_coef_ram.sv
// Coefficient store: synchronous write, registered read. A read of the entry
// being written in the same cycle returns the previous contents.
module ln_coef_ram
    import layer_norm_pkg::*;
#(
    parameter int T_STEPS = LN_T_STEPS,
    parameter int NUM_BLK = LN_NUM_BLK
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_BLK)-1:0] wr_blk,
    input  logic [$clog2(T_STEPS)-1:0] wr_step,
    input  coef_t                      wr_coef,
    input  logic                       rd_en,
    input  logic [$clog2(NUM_BLK)-1:0] rd_blk,
    input  logic [$clog2(T_STEPS)-1:0] rd_step,
    output coef_t                      rd_coef
);

    coef_t mem_r [NUM_BLK][T_STEPS];
    coef_t rd_coef_r;
    logic  wr_ok_s;
    logic  rd_ok_s;

    // Address range qualification; out-of-range writes are dropped and
    // out-of-range reads return a zero coefficient pair.
    always_comb begin
        wr_ok_s = (int'(wr_blk) < NUM_BLK) && (int'(wr_step) < T_STEPS);
        rd_ok_s = (int'(rd_blk) < NUM_BLK) && (int'(rd_step) < T_STEPS);
    end

    // Table storage, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BLK; b++) begin
                for (int s = 0; s < T_STEPS; s++) begin
                    mem_r[b][s] <= '0;
                end
            end
        end else if (wr_en && wr_ok_s) begin
            mem_r[wr_blk][wr_step] <= wr_coef;
        end
    end

    // Registered read port; holds its value when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_coef_r <= '0;
        end else if (rd_en) begin
            rd_coef_r <= rd_ok_s ? mem_r[rd_blk][rd_step] : '0;
        end
    end

    assign rd_coef = rd_coef_r;

endmodule

// File: rtl/layer_norm_bin.sv
// Binarising layer-norm stage: per-(block, step) affine coefficients turn each
// CH-wide spike beat into a new spike vector. Two-stage valid/ready pipeline
// with frame step tracking and a done pulse on the last beat of every frame.
module layer_norm_bin
    import layer_norm_pkg::*;
#(
    parameter int CH      = LN_CH,
    parameter int T_STEPS = LN_T_STEPS,
    parameter int COEF_W  = LN_COEF_W,
    parameter int NUM_BLK = LN_NUM_BLK
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_BLK)-1:0] cfg_blk,
    input  logic [$clog2(T_STEPS)-1:0] cfg_step,
    input  logic signed [COEF_W-1:0]   cfg_alpha,
    input  logic signed [COEF_W-1:0]   cfg_beta,
    input  logic [$clog2(NUM_BLK)-1:0] block_sel,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [CH-1:0]              s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [CH-1:0]              m_data,
    output logic [$clog2(T_STEPS)-1:0] m_step,
    output logic                       m_last,
    output logic                       done
);

    localparam int BLK_W  = $clog2(NUM_BLK);
    localparam int STEP_W = $clog2(T_STEPS);

    // Frame tracking
    logic [STEP_W-1:0] step_r;
    logic [BLK_W-1:0]  blk_r;
    logic              ready_en_r;

    // Stage 1
    logic              v1_r;
    logic [CH-1:0]     d1_r;
    logic [STEP_W-1:0] step1_r;
    logic              last1_r;
    coef_t             coef1_s;

    // Stage 2 (output)
    logic              m_valid_r;
    logic [CH-1:0]     m_data_r;
    logic [STEP_W-1:0] m_step_r;
    logic              m_last_r;
    logic              done_r;

    // Combinational control
    logic              adv2_s;
    logic              s_ready_s;
    logic              in_hs_s;
    logic              step_last_s;
    logic [BLK_W-1:0]  cur_blk_s;
    logic [CH-1:0]     spike_s;
    coef_t             cfg_coef_s;

    // Handshake, block selection for the incoming beat and the spike compare.
    always_comb begin
        adv2_s      = (!m_valid_r) || m_ready;
        s_ready_s   = ready_en_r && ((!v1_r) || adv2_s);
        in_hs_s     = s_valid && s_ready_s;
        step_last_s = (step_r == STEP_W'(T_STEPS - 1));
        cur_blk_s   = (step_r == '0) ? block_sel : blk_r;
        cfg_coef_s.alpha = cfg_alpha;
        cfg_coef_s.beta  = cfg_beta;
        spike_s = '0;
        for (int c = 0; c < CH; c++) begin
            spike_s[c] = spike_bit(d1_r[c], coef1_s);
        end
    end

    // Input is refused while reset is held and for the first edge after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Step counter and per-frame block latch, advanced on each input handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_r <= '0;
            blk_r  <= '0;
        end else if (in_hs_s) begin
            if (step_r == '0) begin
                blk_r <= block_sel;
            end
            step_r <= step_last_s ? '0 : (step_r + STEP_W'(1));
        end
    end

    // Coefficient fetch lands in the same edge as the stage-1 data capture.
    ln_coef_ram #(
        .T_STEPS (T_STEPS),
        .NUM_BLK (NUM_BLK)
    ) u_coef_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cfg_we),
        .wr_blk  (cfg_blk),
        .wr_step (cfg_step),
        .wr_coef (cfg_coef_s),
        .rd_en   (in_hs_s),
        .rd_blk  (cur_blk_s),
        .rd_step (step_r),
        .rd_coef (coef1_s)
    );

    // Stage 1: load a new beat whenever the stage is empty or draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r    <= 1'b0;
            d1_r    <= '0;
            step1_r <= '0;
            last1_r <= 1'b0;
        end else if (s_ready_s) begin
            v1_r <= in_hs_s;
            if (in_hs_s) begin
                d1_r    <= s_data;
                step1_r <= step_r;
                last1_r <= step_last_s;
            end
        end
    end

    // Stage 2: register the spike decision; hold while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_step_r  <= '0;
            m_last_r  <= 1'b0;
        end else if (adv2_s) begin
            m_valid_r <= v1_r;
            if (v1_r) begin
                m_data_r <= spike_s;
                m_step_r <= step1_r;
                m_last_r <= last1_r;
            end
        end
    end

    // One-cycle done pulse after the frame's last beat is taken downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= m_valid_r && m_ready && m_last_r;
        end
    end

    assign s_ready = s_ready_s;
    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign m_step  = m_step_r;
    assign m_last  = m_last_r;
    assign done    = done_r;

endmodule
